// File: rtl/mme_pkg.sv
// Shared state encodings and default datapath widths for the matrix-multiply engine.
// Pure declarations: no logic, no latency, no flow control.
package mme_pkg;

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    localparam int DEFAULT_A_DATA_WIDTH   = 8;
    localparam int DEFAULT_B_DATA_WIDTH   = 8;
    localparam int DEFAULT_RES_DATA_WIDTH = 32;
    localparam int DEFAULT_CNT_WIDTH      = 16;

    typedef enum logic {
        S_ACCUM = ST_ACCUM,
        S_HOLD  = ST_HOLD
    } acc_state_e;

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Element-pair input stream and result output stream of the dot-product stage.
// slave is the accumulator's view; master is the view of the surrounding fetch/writer logic.
interface dot_product_accumulator_if
    import mme_pkg::*;
#(
    parameter int A_DATA_WIDTH   = DEFAULT_A_DATA_WIDTH,
    parameter int B_DATA_WIDTH   = DEFAULT_B_DATA_WIDTH,
    parameter int RES_DATA_WIDTH = DEFAULT_RES_DATA_WIDTH,
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [A_DATA_WIDTH-1:0]   in_a;
    logic [B_DATA_WIDTH-1:0]   in_b;
    logic                      in_last;

    logic                      out_valid;
    logic                      out_ready;
    logic [RES_DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]      out_count;
    logic                      out_overflow;

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_overflow
    );

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_overflow
    );

endinterface

// File: rtl/dot_product_accumulator_mult_and_sum.sv
// Combinational multiply-accumulate: res = a*b + sum, unsigned, wrapping modulo 2^RES_DATA_WIDTH.
// Zero latency, no flow control.
module mult_and_sum #(
    parameter int A_DATA_WIDTH   = 8,
    parameter int B_DATA_WIDTH   = 8,
    parameter int RES_DATA_WIDTH = 32
) (
    input  logic [A_DATA_WIDTH-1:0]   a,
    input  logic [B_DATA_WIDTH-1:0]   b,
    input  logic [RES_DATA_WIDTH-1:0] sum,
    output logic [RES_DATA_WIDTH-1:0] res
);

    localparam int PROD_WIDTH = A_DATA_WIDTH + B_DATA_WIDTH;

    logic [PROD_WIDTH-1:0] prod;

    assign prod = PROD_WIDTH'(a) * PROD_WIDTH'(b);
    assign res  = sum + RES_DATA_WIDTH'(prod);

endmodule

// File: rtl/dot_product_accumulator.sv
// Sequential dot product over a valid/ready pair stream; result valid 1 cycle after the last beat.
// While a result is held, in_ready is low until the downstream takes it with out_ready.
module dot_product_accumulator
    import mme_pkg::*;
#(
    parameter int A_DATA_WIDTH   = DEFAULT_A_DATA_WIDTH,
    parameter int B_DATA_WIDTH   = DEFAULT_B_DATA_WIDTH,
    parameter int RES_DATA_WIDTH = DEFAULT_RES_DATA_WIDTH,
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    dot_product_accumulator_if.slave  bus
);

    localparam int PROD_WIDTH = A_DATA_WIDTH + B_DATA_WIDTH;

    acc_state_e                state_q, state_d;
    logic [RES_DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic [RES_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]      out_count_q, out_count_d;
    logic                      out_ovf_q, out_ovf_d;

    logic [RES_DATA_WIDTH-1:0] mac_res;
    logic [PROD_WIDTH-1:0]     prod;
    logic [RES_DATA_WIDTH:0]   carry_sum;
    logic                      carry;
    logic [CNT_WIDTH-1:0]      cnt_inc;
    logic                      beat;

    mult_and_sum #(
        .A_DATA_WIDTH   (A_DATA_WIDTH),
        .B_DATA_WIDTH   (B_DATA_WIDTH),
        .RES_DATA_WIDTH (RES_DATA_WIDTH)
    ) u_mac (
        .a   (bus.in_a),
        .b   (bus.in_b),
        .sum (acc_q),
        .res (mac_res)
    );

    // Wrap detection runs one bit wider than the accumulator, alongside the MAC.
    assign prod      = PROD_WIDTH'(bus.in_a) * PROD_WIDTH'(bus.in_b);
    assign carry_sum = {1'b0, acc_q} + (RES_DATA_WIDTH + 1)'(prod);
    assign carry     = carry_sum[RES_DATA_WIDTH];

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign beat    = bus.in_valid && (state_q == S_ACCUM);

    assign bus.in_ready     = (state_q == S_ACCUM);
    assign bus.out_valid    = (state_q == S_HOLD);
    assign bus.out_data     = out_data_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_overflow = out_ovf_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            S_ACCUM: begin
                if (beat) begin
                    acc_d = mac_res;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | carry;
                    if (bus.in_last) begin
                        out_data_d  = mac_res;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_q | carry;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Output registers keep their value after hand-off; out_valid alone qualifies them.
                if (bus.out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            default: begin
                state_d = S_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed and randomized-gap checks of the dot-product stage at 32-bit and 16-bit result widths.
module tb_dot_product_accumulator;
    import mme_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dot_product_accumulator_if #(.A_DATA_WIDTH(8), .B_DATA_WIDTH(8), .RES_DATA_WIDTH(32), .CNT_WIDTH(16)) bus32 ();
    dot_product_accumulator_if #(.A_DATA_WIDTH(8), .B_DATA_WIDTH(8), .RES_DATA_WIDTH(16), .CNT_WIDTH(16)) bus16 ();

    dot_product_accumulator #(.A_DATA_WIDTH(8), .B_DATA_WIDTH(8), .RES_DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    dot_product_accumulator #(.A_DATA_WIDTH(8), .B_DATA_WIDTH(8), .RES_DATA_WIDTH(16), .CNT_WIDTH(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pair on the selected DUT and hold it until accepted (bounded).
    task automatic send(input int which, input logic [7:0] a, input logic [7:0] b, input logic last, output logic ok);
        logic took;
        int   n;
        if (which == 16) begin
            bus16.in_a = a; bus16.in_b = b; bus16.in_last = last; bus16.in_valid = 1'b1;
        end else begin
            bus32.in_a = a; bus32.in_b = b; bus32.in_last = last; bus32.in_valid = 1'b1;
        end
        took = 1'b0;
        n = 0;
        while (!took && n < 100) begin
            took = (which == 16) ? bus16.in_ready : bus32.in_ready;
            step();
            n++;
        end
        if (which == 16) begin
            bus16.in_valid = 1'b0; bus16.in_last = 1'b0;
        end else begin
            bus32.in_valid = 1'b0; bus32.in_last = 1'b0;
        end
        ok = took;
        if (!took) begin
            checks++; errors++;
            $display("FAIL send_timeout dut=%0d a=%0d b=%0d in_ready stayed 0 for 100 cycles", which, a, b);
        end
    endtask

    task automatic accept32();
        bus32.out_ready = 1'b1;
        step();
        bus32.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus32.in_ready); end
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus32.out_valid); end
        checks++; if (bus32.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", bus32.out_data); end
        checks++; if (bus32.out_count !== 16'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", bus32.out_count); end
        checks++; if (bus32.out_overflow !== 1'b0) begin errors++; $display("FAIL reset_out_overflow got %b want 0", bus32.out_overflow); end
        checks++; if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin errors++; $display("FAIL reset16_handshake got rdy=%b vld=%b want rdy=1 vld=0", bus16.in_ready, bus16.out_valid); end
    endtask

    task automatic test_basic();
        logic ok;
        bus32.out_ready = 1'b1;
        send(32, 8'd1, 8'd4, 1'b0, ok);
        send(32, 8'd2, 8'd5, 1'b0, ok);
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early_valid got %b want 0", bus32.out_valid); end
        send(32, 8'd3, 8'd6, 1'b1, ok);
        checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", bus32.out_valid); end
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_hold got %b want 0", bus32.in_ready); end
        checks++; if (bus32.out_data !== 32'd32) begin errors++; $display("FAIL basic_out_data got %0d want 32", bus32.out_data); end
        checks++; if (bus32.out_count !== 16'd3) begin errors++; $display("FAIL basic_out_count got %0d want 3", bus32.out_count); end
        checks++; if (bus32.out_overflow !== 1'b0) begin errors++; $display("FAIL basic_out_overflow got %b want 0", bus32.out_overflow); end
        step();
        bus32.out_ready = 1'b0;
        checks++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin errors++; $display("FAIL basic_release got vld=%b rdy=%b want vld=0 rdy=1", bus32.out_valid, bus32.in_ready); end
        checks++; if (bus32.out_data !== 32'd32) begin errors++; $display("FAIL basic_data_kept got %0d want 32", bus32.out_data); end
    endtask

    task automatic test_backpressure();
        logic ok;
        bus32.out_ready = 1'b0;
        send(32, 8'd1, 8'd4, 1'b0, ok);
        send(32, 8'd2, 8'd5, 1'b0, ok);
        send(32, 8'd3, 8'd6, 1'b1, ok);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d got %b want 1", i, bus32.out_valid); end
            checks++; if (bus32.out_data !== 32'd32) begin errors++; $display("FAIL bp_out_data cycle %0d got %0d want 32", i, bus32.out_data); end
            checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, bus32.in_ready); end
            step();
        end
        accept32();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL bp_released got %b want 0", bus32.out_valid); end
        send(32, 8'd2, 8'd2, 1'b1, ok);
        checks++; if (bus32.out_data !== 32'd4) begin errors++; $display("FAIL bp_acc_cleared got %0d want 4", bus32.out_data); end
        checks++; if (bus32.out_count !== 16'd1) begin errors++; $display("FAIL bp_count_cleared got %0d want 1", bus32.out_count); end
        accept32();
    endtask

    task automatic test_single_max();
        logic ok;
        send(32, 8'd255, 8'd255, 1'b1, ok);
        checks++; if (bus32.out_data !== 32'd65025) begin errors++; $display("FAIL single_out_data got %0d want 65025", bus32.out_data); end
        checks++; if (bus32.out_count !== 16'd1) begin errors++; $display("FAIL single_out_count got %0d want 1", bus32.out_count); end
        checks++; if (bus32.out_overflow !== 1'b0) begin errors++; $display("FAIL single_out_overflow got %b want 0", bus32.out_overflow); end
        accept32();
    endtask

    task automatic test_overflow16();
        logic ok;
        bus16.out_ready = 1'b0;
        send(16, 8'd255, 8'd255, 1'b0, ok);
        send(16, 8'd255, 8'd255, 1'b1, ok);
        checks++; if (bus16.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_out_valid got %b want 1", bus16.out_valid); end
        checks++; if (bus16.out_data !== 16'd64514) begin errors++; $display("FAIL ovf_out_data got %0d want 64514", bus16.out_data); end
        checks++; if (bus16.out_count !== 16'd2) begin errors++; $display("FAIL ovf_out_count got %0d want 2", bus16.out_count); end
        checks++; if (bus16.out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag_set got %b want 1", bus16.out_overflow); end
        bus16.out_ready = 1'b1;
        step();
        bus16.out_ready = 1'b0;
        send(16, 8'd1, 8'd1, 1'b1, ok);
        checks++; if (bus16.out_data !== 16'd1) begin errors++; $display("FAIL ovf_next_data got %0d want 1", bus16.out_data); end
        checks++; if (bus16.out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag_cleared got %b want 0", bus16.out_overflow); end
        bus16.out_ready = 1'b1;
        step();
        bus16.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic ok;
        send(32, 8'd10, 8'd10, 1'b0, ok);
        send(32, 8'd10, 8'd10, 1'b0, ok);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_handshake got vld=%b rdy=%b want vld=0 rdy=1", bus32.out_valid, bus32.in_ready); end
        checks++; if (bus32.out_data !== 32'd0) begin errors++; $display("FAIL rst_mid_out_data got %0d want 0", bus32.out_data); end
        checks++; if (bus32.out_count !== 16'd0 || bus32.out_overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_count_ovf got cnt=%0d ovf=%b want 0 0", bus32.out_count, bus32.out_overflow); end
        send(32, 8'd3, 8'd3, 1'b1, ok);
        checks++; if (bus32.out_data !== 32'd9) begin errors++; $display("FAIL rst_mid_after_data got %0d want 9", bus32.out_data); end
        checks++; if (bus32.out_count !== 16'd1) begin errors++; $display("FAIL rst_mid_after_count got %0d want 1", bus32.out_count); end
        // Reset while the result is still pending.
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus32.out_valid !== 1'b0 || bus32.out_data !== 32'd0) begin errors++; $display("FAIL rst_hold_drop got vld=%b data=%0d want 0 0", bus32.out_valid, bus32.out_data); end
        send(32, 8'd2, 8'd3, 1'b1, ok);
        checks++; if (bus32.out_data !== 32'd6 || bus32.out_count !== 16'd1) begin errors++; $display("FAIL rst_hold_after got data=%0d cnt=%0d want 6 1", bus32.out_data, bus32.out_count); end
        accept32();
    endtask

    task automatic test_random();
        int unsigned exp_sum[$];
        int unsigned exp_cnt[$];
        logic        abort;
        abort = 1'b0;
        fork
            begin : producer
                logic [7:0]  va[20];
                logic [7:0]  vb[20];
                int unsigned len, sum;
                logic        ok;
                for (int v = 0; v < 200 && !abort; v++) begin
                    len = $urandom_range(1, 20);
                    sum = 0;
                    for (int i = 0; i < len; i++) begin
                        va[i] = 8'($urandom_range(0, 255));
                        vb[i] = 8'($urandom_range(0, 255));
                        sum += va[i] * vb[i];
                    end
                    exp_sum.push_back(sum);
                    exp_cnt.push_back(len);
                    for (int i = 0; i < len && !abort; i++) begin
                        repeat ($urandom_range(0, 3) == 3 ? $urandom_range(1, 3) : 0) step();
                        send(32, va[i], vb[i], (i == len - 1), ok);
                        if (!ok) abort = 1'b1;
                    end
                end
            end
            begin : consumer
                int          got, cyc;
                int unsigned es, ec;
                logic        rdy;
                got = 0;
                cyc = 0;
                while (got < 200 && cyc < 40000 && !abort) begin
                    rdy = ($urandom_range(0, 2) != 0);
                    bus32.out_ready = rdy;
                    if (bus32.out_valid && rdy) begin
                        es = (exp_sum.size() > 0) ? exp_sum.pop_front() : 32'hFFFF_FFFF;
                        ec = (exp_cnt.size() > 0) ? exp_cnt.pop_front() : 32'hFFFF_FFFF;
                        checks++; if (bus32.out_data !== es) begin errors++; $display("FAIL rand_data vec %0d got %0d want %0d", got, bus32.out_data, es); end
                        checks++; if (32'(bus32.out_count) !== ec) begin errors++; $display("FAIL rand_count vec %0d got %0d want %0d", got, bus32.out_count, ec); end
                        checks++; if (bus32.out_overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow vec %0d got %b want 0", got, bus32.out_overflow); end
                        got++;
                    end
                    step();
                    cyc++;
                end
                bus32.out_ready = 1'b0;
                checks++;
                if (got != 200) begin errors++; $display("FAIL rand_result_count got %0d want 200", got); end
            end
        join
    endtask

    initial begin
        reset = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_last = 1'b0; bus32.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_last = 1'b0; bus16.out_ready = 1'b0;
        step();
        test_reset();
        test_basic();
        test_backpressure();
        test_single_max();
        test_overflow16();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
